regfile_operand_fetch: RTL
==========================

// Module: regfile_operand_fetch
// PURPOSE
//  Operand-fetch stage between decode and execute. It drives the read addresses of the BRAM register file and owns its write port.
//  The regfile muxes its single address per bank (we ? wa : ra), so a writeback in the issue cycle destroys the read.
//  This block retries that read, forwards writebacks that land after the read, and holds operands under a valid/ready handshake.
// PARAMETERS
//  WIDTH  32  data width of registers, wb_wd and operands
// PORTS
//  clk           in   1      clock; all state updates on posedge
//  rst           in   1      synchronous reset, active-high
//  req_valid     in   1      decode presents ra0/ra1
//  req_ready     out  1      fetch accepts request (IDLE only)
//  req_ra0       in   5      source register 0
//  req_ra1       in   5      source register 1
//  wb_we         in   1      writeback enable from commit stage
//  wb_wa         in   5      writeback address
//  wb_wd         in   WIDTH  writeback data
//  rf_ra0        out  5      to regfile ra0
//  rf_ra1        out  5      to regfile ra1
//  rf_we         out  1      to regfile we (wb_we, forced 0 during rst)
//  rf_wa         out  5      to regfile wa (= wb_wa)
//  rf_wd         out  WIDTH  to regfile wd (= wb_wd)
//  rf_rd0        in   WIDTH  regfile rd0, valid one cycle after address issue
//  rf_rd1        in   WIDTH  regfile rd1
//  out_valid     out  1      operands valid to execute
//  out_ready     in   1      execute consumes operands
//  out_rd0       out  WIDTH  operand 0
//  out_rd1       out  WIDTH  operand 1
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, out_rd0/1=0, latched ra=0, rf_we=0. Reset mid-operation aborts; the in-flight request is dropped.
//  - States: IDLE, PEND, DATA, HOLD. Encoding 2'b00..2'b11.
//  - IDLE: req_ready=1; rf_ra* = req_ra*. On req_valid, latch ra0/ra1.
//      If wb_we=0 in that cycle, the read has issued: go to DATA. If wb_we=1, the read was lost: go to PEND.
//  - PEND: rf_ra* = latched ra. If wb_we=0, the read issues: go to DATA. Otherwise stay; each stay cycle counts as a stall.
//  - DATA: capture rf_rd* into out_rd*, then go to HOLD.
//      Capture uses forwarding: if wb_we and wb_wa==ra and ra!=0, capture wb_wd instead.
//  - HOLD: out_valid=1. While waiting, a wb write matching a held ra (ra!=0) replaces that operand at the next edge.
//      On out_ready=1, go to IDLE; out_valid drops next cycle.
//      A same-cycle wb write plus out_ready: the consumer sees the old value; no further effect.
//  - ra==0: operand is always 0 and is never forwarded (the regfile already zeroes x0).
//  - If both operands match wb_wa, both are forwarded. Latency is 2 cycles req-to-out_valid without conflict, +N per conflicting cycle.
//  - rf_ra* in DATA/HOLD = latched ra (don't care to regfile, held stable).
// CONFIGURATION
//  OPFETCH_STATS_EN defined: adds output ports stat_stall [31:0] and stat_fwd [31:0].
//    stat_stall counts cycles entered/held in PEND. stat_fwd counts operand forwards in DATA or HOLD (+2 if both operands).
//    Both counters are saturating and reset to 0.
//  Undefined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package pcpu_defs: OPF_IDLE/PEND/DATA/HOLD state constants, REG_ZERO=5'd0, REG_AW=5.
//  Sub-module opfetch_fwd: per-operand compare (wb_we, wb_wa, ra!=0); instantiated twice.
//  Top level holds the FSM, latches and optional counters.
// TESTING
//  1. No conflict: req ra0=3, ra1=5 (regs 0x11/0x22), wb_we=0 -> out_valid at +2, out 0x11/0x22.
//  2. Conflict: req with wb_we=1 for 2 cycles -> PEND 2 cycles, out_valid at +4; stat_stall=2 with OPFETCH_STATS_EN.
//  3. DATA-cycle forward: read r7=0xA, wb r7<=0xB in DATA cycle -> out_rd0=0xB.
//  4. HOLD update: out_ready=0, wb r5<=0x99 -> out_rd1 becomes 0x99 next cycle; wb r0<=0x55 -> operand stays 0.
//  5. Backpressure: out_ready=0 for 5 cycles -> out_valid stays 1, req_ready=0; out_ready=1 -> IDLE next cycle.
//  6. rst asserted in PEND/HOLD -> next cycle IDLE, out_valid=0, outputs 0, rf_we=0.

Source files
------------

// File: rtl/regfile_operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage.
// Contents:
//   opf_state_e : FSM state encoding (IDLE/PEND/DATA/HOLD = 2'b00..2'b11)
//   REG_AW      : register address width
//   REG_ZERO    : architectural zero register x0
//   sat_add32   : saturating 32-bit counter increment
package regfile_operand_fetch_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        OPF_IDLE = 2'b00,
        OPF_PEND = 2'b01,
        OPF_DATA = 2'b10,
        OPF_HOLD = 2'b11
    } opf_state_e;

    // Adds a small increment and pins at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] base, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, base} + {31'b0, inc};
        if (sum[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/regfile_operand_fetch_if.sv
// Bus between the operand-fetch stage and the BRAM register file.
// The regfile has one address per bank, muxed as (we ? wa : ra).
// Signals:
//   ra0/ra1 : read addresses          we/wa/wd : write port
//   rd0/rd1 : read data, valid one cycle after the address is presented
// Modports: master = fetch stage, slave = register file.
interface regfile_operand_fetch_if
    import regfile_operand_fetch_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic [REG_AW-1:0] ra0;
    logic [REG_AW-1:0] ra1;
    logic              we;
    logic [REG_AW-1:0] wa;
    logic [WIDTH-1:0]  wd;
    logic [WIDTH-1:0]  rd0;
    logic [WIDTH-1:0]  rd1;

    modport master (output ra0, ra1, we, wa, wd, input rd0, rd1);
    modport slave  (input ra0, ra1, we, wa, wd, output rd0, rd1);
endinterface

// File: rtl/regfile_operand_fetch_fwd.sv
// Per-operand writeback match: a writeback hits an operand when it is
// enabled, targets the same register, and that register is not x0
// (x0 reads as zero and must never pick up forwarded data).
// Ports:
//   wb_we, wb_wa : writeback enable / address
//   ra           : operand's source register
//   hit          : forward wb_wd into this operand
module regfile_operand_fetch_fwd
    import regfile_operand_fetch_pkg::*;
(
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_wa,
    input  logic [REG_AW-1:0] ra,
    output logic              hit
);
    assign hit = wb_we && (wb_wa == ra) && (ra != REG_ZERO);
endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand-fetch stage between decode and execute. Drives the regfile read
// addresses, passes the commit-stage writeback through to the regfile write
// port, retries reads lost to a same-cycle writeback, forwards writebacks
// landing after the read, and holds operands under valid/ready.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready, req_ra0/1 : request from decode (accepted in IDLE)
//   wb_we/wb_wa/wb_wd              : writeback from commit
//   rf (master)                    : regfile bus
//   out_valid/out_ready, out_rd0/1 : operands to execute
//   stat_stall, stat_fwd           : only with OPFETCH_STATS_EN defined
// Configuration macro: OPFETCH_STATS_EN adds saturating stall/forward counters.
module regfile_operand_fetch
    import regfile_operand_fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [REG_AW-1:0]       req_ra0,
    input  logic [REG_AW-1:0]       req_ra1,
    input  logic                    wb_we,
    input  logic [REG_AW-1:0]       wb_wa,
    input  logic [WIDTH-1:0]        wb_wd,
    regfile_operand_fetch_if.master rf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_rd0,
    output logic [WIDTH-1:0]        out_rd1
`ifdef OPFETCH_STATS_EN
    ,
    output logic [31:0]             stat_stall,
    output logic [31:0]             stat_fwd
`endif
);

    opf_state_e        state_r;
    logic [REG_AW-1:0] ra0_r;
    logic [REG_AW-1:0] ra1_r;
    logic              out_valid_r;
    logic [WIDTH-1:0]  out_rd0_r;
    logic [WIDTH-1:0]  out_rd1_r;
    logic              fwd0_s;
    logic              fwd1_s;
    logic [WIDTH-1:0]  cap0_s;
    logic [WIDTH-1:0]  cap1_s;

    // In IDLE the request addresses go straight to the regfile so the read
    // issues in the acceptance cycle; afterwards the latched ones are held.
    assign rf.ra0    = (state_r == OPF_IDLE) ? req_ra0 : ra0_r;
    assign rf.ra1    = (state_r == OPF_IDLE) ? req_ra1 : ra1_r;
    assign rf.we     = wb_we & ~rst;
    assign rf.wa     = wb_wa;
    assign rf.wd     = wb_wd;
    assign req_ready = (state_r == OPF_IDLE);

    assign out_valid = out_valid_r;
    assign out_rd0   = out_rd0_r;
    assign out_rd1   = out_rd1_r;

    regfile_operand_fetch_fwd u_fwd0 (.wb_we(wb_we), .wb_wa(wb_wa), .ra(ra0_r), .hit(fwd0_s));
    regfile_operand_fetch_fwd u_fwd1 (.wb_we(wb_we), .wb_wa(wb_wa), .ra(ra1_r), .hit(fwd1_s));

    // Capture value for DATA: forwarded writeback beats regfile data, x0 is zero.
    always_comb begin
        cap0_s = rf.rd0;
        cap1_s = rf.rd1;
        if (fwd0_s) begin
            cap0_s = wb_wd;
        end else if (ra0_r == REG_ZERO) begin
            cap0_s = {WIDTH{1'b0}};
        end else begin
            cap0_s = rf.rd0;
        end
        if (fwd1_s) begin
            cap1_s = wb_wd;
        end else if (ra1_r == REG_ZERO) begin
            cap1_s = {WIDTH{1'b0}};
        end else begin
            cap1_s = rf.rd1;
        end
    end

    // Fetch FSM with latched addresses and registered operand outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= OPF_IDLE;
            ra0_r       <= REG_ZERO;
            ra1_r       <= REG_ZERO;
            out_valid_r <= 1'b0;
            out_rd0_r   <= {WIDTH{1'b0}};
            out_rd1_r   <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                OPF_IDLE: begin
                    if (req_valid) begin
                        ra0_r   <= req_ra0;
                        ra1_r   <= req_ra1;
                        // A writeback this cycle stole the bank address: retry.
                        state_r <= wb_we ? OPF_PEND : OPF_DATA;
                    end
                end
                OPF_PEND: begin
                    if (!wb_we) begin
                        state_r <= OPF_DATA;
                    end
                end
                OPF_DATA: begin
                    out_rd0_r   <= cap0_s;
                    out_rd1_r   <= cap1_s;
                    out_valid_r <= 1'b1;
                    state_r     <= OPF_HOLD;
                end
                OPF_HOLD: begin
                    if (out_ready) begin
                        // Consumer takes the current values; a same-cycle
                        // writeback is deliberately not applied.
                        out_valid_r <= 1'b0;
                        state_r     <= OPF_IDLE;
                    end else begin
                        if (fwd0_s) begin
                            out_rd0_r <= wb_wd;
                        end
                        if (fwd1_s) begin
                            out_rd1_r <= wb_wd;
                        end
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= OPF_IDLE;
                end
            endcase
        end
    end

`ifdef OPFETCH_STATS_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] fwd_cnt_r;
    logic        stall_inc_s;
    logic [1:0]  fwd_inc_s;

    // Stall = every cycle that enters or stays in PEND; forwards counted per operand.
    always_comb begin
        stall_inc_s = 1'b0;
        fwd_inc_s   = 2'd0;
        case (state_r)
            OPF_IDLE: stall_inc_s = req_valid & wb_we;
            OPF_PEND: stall_inc_s = wb_we;
            OPF_DATA: fwd_inc_s   = {1'b0, fwd0_s} + {1'b0, fwd1_s};
            OPF_HOLD: begin
                if (out_ready) begin
                    fwd_inc_s = 2'd0;
                end else begin
                    fwd_inc_s = {1'b0, fwd0_s} + {1'b0, fwd1_s};
                end
            end
            default: begin
                stall_inc_s = 1'b0;
                fwd_inc_s   = 2'd0;
            end
        endcase
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
            fwd_cnt_r   <= 32'd0;
        end else begin
            stall_cnt_r <= sat_add32(stall_cnt_r, {1'b0, stall_inc_s});
            fwd_cnt_r   <= sat_add32(fwd_cnt_r, fwd_inc_s);
        end
    end

    assign stat_stall = stall_cnt_r;
    assign stat_fwd   = fwd_cnt_r;
`endif

endmodule
